// File: rtl/updown_counter_param_if.sv
// Bundles the control, data and status signals of updown_counter_param.
//
// Ports (signals carried by the interface):
//   en        count enable
//   mode      1 = count up, 0 = count down
//   load      parallel load request (wins over counting)
//   load_val  value to load, clamped to limit
//   step      increment/decrement amount, clamped to limit
//   limit     upper bound, count range is 0..limit
//   sat       1 = saturate at bounds, 0 = wrap modulo (limit+1)
//   clr_flags clears the sticky ovf/udf flags
//   out       registered count value
//   tc        one-cycle terminal-count pulse
//   ovf/udf   sticky overflow/underflow flags
//   is_zero   high while out == 0
//
// Modports: master drives the controls, slave is the counter.
interface updown_counter_param_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              en;
    logic              mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  limit;
    logic              sat;
    logic              clr_flags;
    logic [WIDTH-1:0]  out;
    logic              tc;
    logic              ovf;
    logic              udf;
    logic              is_zero;

    modport master (
        output en, mode, load, load_val, step, limit, sat, clr_flags,
        input  out, tc, ovf, udf, is_zero
    );

    modport slave (
        input  en, mode, load, load_val, step, limit, sat, clr_flags,
        output out, tc, ovf, udf, is_zero
    );
endinterface

// File: rtl/updown_counter_param.sv
// Loadable up/down counter with programmable upper bound and step size,
// selectable wrap or saturate behaviour at the bounds, a one-cycle
// terminal-count pulse and sticky overflow/underflow flags.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-low
//   bus  updown_counter_param_if.slave carrying controls and status
//
// Parameters:
//   WIDTH    counter and bound width
//   STEP_W   width of the step input
//   RST_VAL  value of out after reset (keep it <= the limit in use)
module updown_counter_param #(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int RST_VAL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    updown_counter_param_if.slave  bus
);

    // Common width for comparing step against limit without truncating either.
    localparam int SW = (STEP_W > WIDTH) ? STEP_W : WIDTH;
    localparam logic [WIDTH-1:0] RST_OUT = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] out_r;
    logic             tc_r;
    logic             ovf_r;
    logic             udf_r;

    logic [SW-1:0]    step_x;
    logic [SW-1:0]    limit_x;
    logic [WIDTH-1:0] s;

    // One extra bit so limit == all-ones keeps its carry (limit+1 == 2^WIDTH).
    logic [WIDTH:0]   out_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH:0]   lim_ext;
    logic [WIDTH:0]   range;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   wrap_up;
    logic [WIDTH:0]   wrap_dn;

    logic [WIDTH-1:0] out_nxt;
    logic             tc_nxt;
    logic             ovf_set;
    logic             udf_set;

    assign step_x  = SW'(bus.step);
    assign limit_x = SW'(bus.limit);
    assign s       = (step_x > limit_x) ? bus.limit : step_x[WIDTH-1:0];

    assign out_ext = {1'b0, out_r};
    assign s_ext   = {1'b0, s};
    assign lim_ext = {1'b0, bus.limit};
    assign range   = lim_ext + {{WIDTH{1'b0}}, 1'b1};
    assign sum_up  = out_ext + s_ext;
    assign wrap_up = sum_up - range;
    assign wrap_dn = out_ext + range - s_ext;

    // Next count value and crossing events; reset is handled in the register.
    always_comb begin
        out_nxt = out_r;
        tc_nxt  = 1'b0;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (bus.load) begin
            out_nxt = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
        end else if (bus.en) begin
            if (out_r > bus.limit) begin
                // Limit was lowered under the count: pull back silently.
                out_nxt = bus.limit;
            end else if (s == '0) begin
                out_nxt = out_r;
            end else if (bus.mode) begin
                if (sum_up <= lim_ext) begin
                    out_nxt = sum_up[WIDTH-1:0];
                end else begin
                    out_nxt = bus.sat ? bus.limit : wrap_up[WIDTH-1:0];
                    tc_nxt  = 1'b1;
                    ovf_set = 1'b1;
                end
            end else begin
                if (out_r >= s) begin
                    out_nxt = out_r - s;
                end else begin
                    out_nxt = bus.sat ? '0 : wrap_dn[WIDTH-1:0];
                    tc_nxt  = 1'b1;
                    udf_set = 1'b1;
                end
            end
        end
    end

    // Flags: a new crossing wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_r <= RST_OUT;
            tc_r  <= 1'b0;
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            out_r <= out_nxt;
            tc_r  <= tc_nxt;
            ovf_r <= ovf_set | (ovf_r & ~bus.clr_flags);
            udf_r <= udf_set | (udf_r & ~bus.clr_flags);
        end
    end

    assign bus.out     = out_r;
    assign bus.tc      = tc_r;
    assign bus.ovf     = ovf_r;
    assign bus.udf     = udf_r;
    assign bus.is_zero = (out_r == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param: directed scenarios followed
// by randomized traffic, all compared against an integer reference model.
module tb_updown_counter_param;

    localparam int WIDTH   = 8;
    localparam int STEP_W  = 4;
    localparam int RST_VAL = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state
    int m_out = RST_VAL;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_udf = 0;

    updown_counter_param_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    updown_counter_param #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W),
        .RST_VAL(RST_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference behaviour with plain integer arithmetic on the range 0..lim.
    task automatic modelStep(input int r, input int e, input int md, input int ld, input int lv,
                             input int st, input int lim, input int sa, input int cf);
        int o, s, ov, ud, t;
        if (r == 0) begin
            m_out = RST_VAL; m_tc = 0; m_ovf = 0; m_udf = 0;
            return;
        end
        o = m_out; ov = 0; ud = 0; t = 0;
        if (ld != 0) begin
            o = (lv < lim) ? lv : lim;
        end else if (e != 0) begin
            s = (st < lim) ? st : lim;
            if (m_out > lim) o = lim;
            else if (s == 0) o = m_out;
            else if (md != 0) begin
                if (m_out + s <= lim) o = m_out + s;
                else begin
                    o  = (sa != 0) ? lim : (m_out + s) % (lim + 1);
                    t  = 1; ov = 1;
                end
            end else begin
                if (m_out - s >= 0) o = m_out - s;
                else begin
                    o  = (sa != 0) ? 0 : m_out - s + (lim + 1);
                    t  = 1; ud = 1;
                end
            end
        end
        m_out = o;
        m_tc  = t;
        m_ovf = (ov != 0 || (m_ovf != 0 && cf == 0)) ? 1 : 0;
        m_udf = (ud != 0 || (m_udf != 0 && cf == 0)) ? 1 : 0;
    endtask

    // Drive one cycle, step the model, then compare everything #1 after the edge.
    task automatic applyStimulus(input int r, input int e, input int md, input int ld, input int lv,
                                 input int st, input int lim, input int sa, input int cf);
        rst           = r[0];
        bus.en        = e[0];
        bus.mode      = md[0];
        bus.load      = ld[0];
        bus.load_val  = lv[WIDTH-1:0];
        bus.step      = st[STEP_W-1:0];
        bus.limit     = lim[WIDTH-1:0];
        bus.sat       = sa[0];
        bus.clr_flags = cf[0];
        @(posedge clk);
        modelStep(r, e, md, ld, lv, st, lim, sa, cf);
        #1;
        checkOutput("out",     int'(bus.out), m_out);
        checkOutput("tc",      int'(bus.tc),  m_tc);
        checkOutput("ovf",     int'(bus.ovf), m_ovf);
        checkOutput("udf",     int'(bus.udf), m_udf);
        checkOutput("is_zero", int'(bus.is_zero), (m_out == 0) ? 1 : 0);
        #3;
    endtask

    initial begin
        int lim, e, md, ld, sa, cf, r;

        // 1: reset dominates an active load and count
        applyStimulus(0, 1, 1, 1, 55, 1, 255, 0, 0);
        applyStimulus(0, 1, 1, 1, 55, 1, 255, 0, 0);
        checkOutput("t1_rst_out", int'(bus.out), 0);
        checkOutput("t1_rst_zero", int'(bus.is_zero), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 1, 255, 0, 0);
        checkOutput("t1_count3", int'(bus.out), 3);

        // 2: up wrap at limit 9, then wrap with a larger step
        applyStimulus(1, 0, 1, 1, 0, 1, 9, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 1, 1, 0, 0, 1, 9, 0, 0);
        checkOutput("t2_wrap_out", int'(bus.out), 0);
        checkOutput("t2_wrap_tc", int'(bus.tc), 1);
        applyStimulus(1, 0, 1, 1, 8, 3, 9, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 3, 9, 0, 0);
        checkOutput("t2_step3_out", int'(bus.out), 1);
        checkOutput("t2_step3_tc", int'(bus.tc), 1);

        // 3: down saturate, repeated tc at the bound, flag clear
        applyStimulus(1, 0, 0, 1, 2, 3, 99, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 3, 99, 1, 0);
        applyStimulus(1, 1, 0, 0, 0, 3, 99, 1, 0);
        checkOutput("t3_sat_tc_again", int'(bus.tc), 1);
        applyStimulus(1, 0, 0, 0, 0, 3, 99, 1, 1);
        checkOutput("t3_udf_clr", int'(bus.udf), 0);

        // 4: load clamp, then limit lowered below the count
        applyStimulus(1, 1, 1, 1, 200, 1, 99, 0, 0);
        checkOutput("t4_clamp", int'(bus.out), 99);
        applyStimulus(1, 1, 1, 0, 0, 1, 50, 0, 0);
        checkOutput("t4_pull_back", int'(bus.out), 50);

        // 5: full-range wrap with clear in the same cycle
        applyStimulus(1, 0, 1, 1, 250, 15, 255, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 15, 255, 0, 1);
        checkOutput("t5_out", int'(bus.out), 9);
        checkOutput("t5_ovf_set_wins", int'(bus.ovf), 1);

        // 6: reset right after a wrap
        applyStimulus(0, 1, 1, 0, 0, 15, 255, 0, 0);
        checkOutput("t6_rst_tc", int'(bus.tc), 0);

        // Randomized traffic with occasional limit changes and resets
        lim = 255;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                case ($urandom_range(0, 3))
                    0: lim = 255;
                    1: lim = $urandom_range(0, 3);
                    default: lim = $urandom_range(0, 255);
                endcase
            end
            r  = ($urandom_range(0, 63) == 0) ? 0 : 1;
            e  = ($urandom_range(0, 5) != 0) ? 1 : 0;
            md = $urandom_range(0, 1);
            ld = ($urandom_range(0, 11) == 0) ? 1 : 0;
            sa = ($urandom_range(0, 2) == 0) ? 1 : 0;
            cf = ($urandom_range(0, 15) == 0) ? 1 : 0;
            applyStimulus(r, e, md, ld, $urandom_range(0, 255), $urandom_range(0, 15), lim, sa, cf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
